// File: rtl/merge_pkg.sv
// Shared types and helpers for the sign-select merge pipeline.
package merge_pkg;

   typedef enum logic [1:0] {
      MODE_SEL = 2'b00,
      MODE_ACC = 2'b01,
      MODE_SUM = 2'b10,
      MODE_RSV = 2'b11
   } mode_e;

   // Sign-select merge: both-positive gives 0, only B negative passes the
   // sticky bit, A negative inverts it.
   function automatic logic sel_y(input logic signa, input logic signb, input logic sticky);
      logic y;
      case ({signa, signb})
         2'b00:   y = 1'b0;
         2'b01:   y = sticky;
         default: y = !sticky;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/pipe_slice.sv
// Single valid/ready register stage; data moves on in_valid && in_ready,
// and the stage may refill in the same cycle its contents are taken.
module pipe_slice #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   // Valid/ready: a beat transfers on any rising edge with valid && ready;
   // valid never waits on ready, and data holds while valid && !ready.
   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) out_data <= in_data;
      end
   end

endmodule

// File: rtl/merge_select_pipe.sv
// Two-stage operand merge: S1 registers operands, the S1->S2 path forms the
// sum, sticky and sign-selected result, S2 holds the result for the sink.
module merge_select_pipe
   import merge_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             in_last,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_flag
);

   localparam int S1W = 2*WIDTH + 3;

   logic             s1_valid;
   logic             s2_free;
   logic [S1W-1:0]   s1_data;
   logic [WIDTH-1:0] opa_r;
   logic [WIDTH-1:0] opb_r;
   logic             last_r;
   mode_e            mode_r;
   logic [WIDTH:0]   sum;
   logic             sticky_now;
   logic             eff_sticky;
   logic             sticky_acc;
   logic [WIDTH-1:0] res_out;
   logic             res_flag;

   pipe_slice #(.W(S1W)) u_s1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({opa, opb, in_last, mode}),
      .out_valid (s1_valid),
      .out_ready (s2_free),
      .out_data  (s1_data)
   );

   assign opa_r  = s1_data[S1W-1 -: WIDTH];
   assign opb_r  = s1_data[WIDTH+2 -: WIDTH];
   assign last_r = s1_data[2];
   assign mode_r = mode_e'(s1_data[1:0]);

   assign sum        = {1'b0, opa_r} + {1'b0, opb_r};
   assign sticky_now = |sum[WIDTH-1:0];
   assign eff_sticky = (mode_r == MODE_ACC) ? (sticky_acc | sticky_now) : sticky_now;

   always_comb begin
      res_out  = '0;
      res_flag = 1'b0;
      if (mode_r == MODE_SUM) begin
         res_out  = sum[WIDTH-1:0];
         res_flag = sum[WIDTH];
      end else begin
         res_out  = {{(WIDTH-1){1'b0}}, sel_y(opa_r[WIDTH-1], opb_r[WIDTH-1], eff_sticky)};
         res_flag = eff_sticky;
      end
   end

   // The accumulator only advances when the S1 beat actually moves into S2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_acc <= 1'b0;
      end else if (s1_valid && s2_free) begin
         sticky_acc <= (mode_r == MODE_ACC && !last_r) ? eff_sticky : 1'b0;
      end
   end

   pipe_slice #(.W(WIDTH+1)) u_s2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s1_valid),
      .in_ready  (s2_free),
      .in_data   ({res_out, res_flag}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  ({out, out_flag})
   );

endmodule

// File: tb/tb_merge_select_pipe.sv
// Directed bench for merge_select_pipe at WIDTH=32.
module tb_merge_select_pipe;
   import merge_pkg::*;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] opa = '0;
   logic [WIDTH-1:0] opb = '0;
   logic             in_last = 1'b0;
   logic [1:0]       mode = 2'b00;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out;
   logic             out_flag;

   int checks = 0;
   int errors = 0;
   logic [WIDTH:0] exp_q[$];

   merge_select_pipe #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opa       (opa),
      .opb       (opb),
      .in_last   (in_last),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_flag  (out_flag)
   );

   // clock / reset
   always #5 clk = ~clk;

   // driver tasks
   task automatic set_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic last, input logic [1:0] m);
      in_valid = 1'b1;
      opa      = a;
      opb      = b;
      in_last  = last;
      mode     = m;
   endtask

   task automatic send_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic last, input logic [1:0] m);
      int budget;
      set_beat(a, b, last, m);
      budget = 0;
      @(negedge clk);
      while (!in_ready && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 20) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if ({in_ready, out_valid, out, out_flag} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state got rdy=%0b vld=%0b out=%h flag=%0b required 1 0 0 0",
                  in_ready, out_valid, out, out_flag);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_sel();
      logic [WIDTH-1:0] a_t[3] = '{32'h00000001, 32'hFFFFFFFF, 32'h80000000};
      logic [WIDTH-1:0] b_t[3] = '{32'h80000000, 32'h00000001, 32'h00000000};
      logic [WIDTH-1:0] o_t[3] = '{32'h00000001, 32'h00000001, 32'h00000000};
      logic             f_t[3] = '{1'b1, 1'b0, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send_beat(a_t[i], b_t[i], 1'b0, MODE_SEL);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sel_latency_%0d out_valid=%0b required=0", i, out_valid);
         end
         @(posedge clk);
         #1;
         checks++;
         if ({out_valid, out, out_flag} !== {1'b1, o_t[i], f_t[i]}) begin
            errors++;
            $display("FAIL sel_%0d got vld=%0b out=%h flag=%0b required 1 %h %0b",
                     i, out_valid, out, out_flag, o_t[i], f_t[i]);
         end
      end
   endtask

   task automatic test_acc();
      logic [WIDTH-1:0] a_t[3] = '{32'h1, 32'h1, 32'h1};
      logic [WIDTH-1:0] b_t[3] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic             l_t[3] = '{1'b0, 1'b1, 1'b1};
      logic [WIDTH-1:0] o_t[3] = '{32'h0, 32'h1, 32'h0};
      logic             f_t[3] = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         send_beat(a_t[i], b_t[i], l_t[i], MODE_ACC);
         @(posedge clk);
         #1;
         checks++;
         if ({out_valid, out, out_flag} !== {1'b1, o_t[i], f_t[i]}) begin
            errors++;
            $display("FAIL acc_%0d got vld=%0b out=%h flag=%0b required 1 %h %0b",
                     i, out_valid, out, out_flag, o_t[i], f_t[i]);
         end
      end
   endtask

   task automatic test_sum();
      send_beat(32'hFFFFFFFF, 32'h00000002, 1'b0, MODE_SUM);
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out, out_flag} !== {1'b1, 32'h00000001, 1'b1}) begin
         errors++;
         $display("FAIL sum got vld=%0b out=%h flag=%0b required 1 00000001 1",
                  out_valid, out, out_flag);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] a_t[3] = '{32'd10, 32'd20, 32'd30};
      logic [WIDTH:0]   e_t[3] = '{{32'd11, 1'b0}, {32'd21, 1'b0}, {32'd31, 1'b0}};
      logic [WIDTH:0]   held;
      logic             have_held;
      logic [WIDTH:0]   exp;
      int idx;
      int got;
      int budget;
      idx = 0;
      have_held = 1'b0;
      held = '0;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (idx < 3) set_beat(a_t[idx], 32'd1, 1'b0, MODE_SUM);
         else in_valid = 1'b0;
         @(negedge clk);
         if (out_valid) begin
            if (!have_held) begin
               held = {out, out_flag};
               have_held = 1'b1;
            end else begin
               checks++;
               if ({out, out_flag} !== held) begin
                  errors++;
                  $display("FAIL bp_stable_%0d got %h required %h", c, {out, out_flag}, held);
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(e_t[idx]);
            idx++;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (idx !== 2 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_accepts got accepts=%0d in_ready=%0b required 2 0", idx, in_ready);
      end
      out_ready = 1'b1;
      got = 0;
      budget = 0;
      while ((got < 3) && budget < 20) begin
         if (idx < 3) set_beat(a_t[idx], 32'd1, 1'b0, MODE_SUM);
         else in_valid = 1'b0;
         @(negedge clk);
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL bp_extra got %h required none", {out, out_flag});
            end else begin
               exp = exp_q.pop_front();
               if ({out, out_flag} !== exp) begin
                  errors++;
                  $display("FAIL bp_order_%0d got %h required %h", got, {out, out_flag}, exp);
               end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(e_t[idx]);
            idx++;
         end
         @(posedge clk);
         #1;
         budget++;
      end
      in_valid = 1'b0;
      checks++;
      if (got !== 3 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_count got %0d left %0d required 3 0", got, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      send_beat(32'h1, 32'h0, 1'b0, MODE_ACC);
      send_beat(32'h1, 32'h0, 1'b0, MODE_ACC);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_setup got vld=%0b rdy=%0b required 1 0", out_valid, in_ready);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, out, out_flag, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL rst_mid_async got vld=%0b out=%h flag=%0b rdy=%0b required 0 0 0 1",
                  out_valid, out, out_flag, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      send_beat(32'h1, 32'hFFFFFFFF, 1'b1, MODE_ACC);
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out, out_flag} !== {1'b1, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL rst_mid_acc got vld=%0b out=%h flag=%0b required 1 0 0",
                  out_valid, out, out_flag);
      end
   endtask

   initial begin
      test_reset();
      test_sel();
      test_acc();
      test_sum();
      test_backpressure();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // final report guard against a stuck run
   initial begin
      #50000;
      $display("FAIL watchdog time=%0t required finish", $time);
      $fatal(1);
   end

endmodule
